hood_fan_sequencer: RTL

Fan-motor sequencer for the range hood. It takes the one-hot smoke-level code produced by the hood's mode controller, ramps the fan PWM duty toward the level's target in fixed steps on a 100 Hz tick, and drives the motor PWM pin. It also accumulates fan run time and raises a cleaning reminder once a configurable number of running seconds has elapsed.

---
 rtl/hood_fan_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hood_fan_sequencer.sv
// Range-hood fan sequencer: ramps PWM duty toward the smoke-level target on a
// 100 Hz tick, drives the motor PWM and tracks run time for a cleaning reminder.
module hood_fan_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 8,
    parameter int DUTY_L1    = 64,
    parameter int DUTY_L2    = 128,
    parameter int DUTY_L3    = 255,
    parameter int REMIND_SEC = 36000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_100Hz,
    input  logic [3:0]          state_smoke_lvl,
    input  logic                clear_reminder,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty_cur,
    output logic                ramping,
    output logic                at_target,
    output logic                fan_running,
    output logic [15:0]         usage_seconds,
    output logic                clean_reminder
);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_t;

    localparam logic [PWM_BITS-1:0] STEP_W   = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS+1)'(STEP);
    localparam logic [15:0]         REMIND_W = 16'(REMIND_SEC);

    state_t              state_reg, state_next;
    logic [PWM_BITS-1:0] duty_reg, duty_next;
    logic                at_target_reg, at_target_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                pwm_out_reg;
    logic [6:0]          subtick_reg;
    logic [15:0]         usage_reg;
    logic                reminder_reg;

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   down_floor;
    logic                lvl_off;
    logic                count_en;

    always_comb begin
        target = '0;
        unique case (state_smoke_lvl)
            4'b0001: target = PWM_BITS'(DUTY_L1);
            4'b0010: target = PWM_BITS'(DUTY_L2);
            4'b0100: target = PWM_BITS'(DUTY_L3);
            default: target = '0;
        endcase
    end

    assign lvl_off    = (state_smoke_lvl == 4'b0000);
    // One bit wider so the ramp clamps instead of wrapping at either end.
    assign up_sum     = {1'b0, duty_reg} + STEP_X;
    assign down_floor = {1'b0, target} + STEP_X;

    always_comb begin
        state_next     = state_reg;
        duty_next      = duty_reg;
        at_target_next = at_target_reg;
        if (lvl_off) begin
            state_next     = IDLE;
            duty_next      = '0;
            at_target_next = 1'b1;
        end else if (tick_100Hz) begin
            if (target > duty_reg)
                duty_next = (up_sum >= {1'b0, target}) ? target : up_sum[PWM_BITS-1:0];
            else if (target < duty_reg)
                duty_next = ({1'b0, duty_reg} >= down_floor) ? (duty_reg - STEP_W) : target;

            if (duty_next == '0)
                state_next = IDLE;
            else if (duty_next == target)
                state_next = HOLD;
            else if (target > duty_next)
                state_next = RAMP_UP;
            else
                state_next = RAMP_DOWN;
            at_target_next = (duty_next == target);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            duty_reg      <= '0;
            at_target_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            duty_reg      <= duty_next;
            at_target_reg <= at_target_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
            pwm_out_reg <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
            pwm_out_reg <= (pwm_cnt_reg < duty_reg);
        end
    end

    // A tick coinciding with OFF is dropped from the run-time count.
    assign count_en = tick_100Hz && !lvl_off && (duty_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            subtick_reg  <= '0;
            usage_reg    <= '0;
            reminder_reg <= 1'b0;
        end else begin
            if (clear_reminder) begin
                subtick_reg <= '0;
                usage_reg   <= '0;
            end else if (count_en) begin
                if (subtick_reg == 7'd99) begin
                    subtick_reg <= '0;
                    if (usage_reg != 16'hFFFF)
                        usage_reg <= usage_reg + 16'd1;
                end else begin
                    subtick_reg <= subtick_reg + 7'd1;
                end
            end
            reminder_reg <= (usage_reg >= REMIND_W);
        end
    end

    assign duty_cur       = duty_reg;
    assign ramping        = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);
    assign at_target      = at_target_reg;
    assign fan_running    = (duty_reg != '0);
    assign pwm_out        = pwm_out_reg;
    assign usage_seconds  = usage_reg;
    assign clean_reminder = reminder_reg;

endmodule
